hdlc_tx_framer: RTL and testbench

//  Parametrised HDLC transmit framer for the Hdlc controller: byte buffer, opening/closing 0x7E flags,

---
 rtl/hdlc_tx_framer.sv | 256 +++++++++++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: buffered bytes -> 0x7E flags, zero-stuffed data, optional CRC-16/X.25 FCS (HDLC_FCS_EN), abort.
// One line bit per clock, first flag bit the cycle after Tx_Enable; writes into a full buffer are dropped and flagged.
module hdlc_tx_framer #(
  parameter int BUF_DEPTH = 128,
  parameter int END_FLAGS = 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Tx_Wr,
  input  logic [7:0]                   Tx_Data,
  input  logic                         Tx_Enable,
  input  logic                         Tx_AbortReq,
  output logic                         Tx,
  output logic                         TxEN,
  output logic                         Tx_Busy,
  output logic                         Tx_Full,
  output logic                         Tx_Done,
  output logic                         Tx_Aborted,
  output logic                         Tx_Overflow,
  output logic [$clog2(BUF_DEPTH):0]   Tx_Count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_FLAG,
    ST_DATA,
    ST_FCS,
    ST_END_FLAG,
    ST_ABORT
  } state_t;

  state_t          state;
  logic [7:0]      mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, bytes_left, rd_amt;
  logic [7:0]      rd_byte;
  logic [15:0]     shreg;
  logic [4:0]      bit_cnt;
  logic [2:0]      ones, ones_next;
  logic [1:0]      flag_idx;
  logic            wr_acc, last_flag, abort_go, stuff_next, accept, b2b, load_byte, data_bit;

  assign rd_byte  = mem[rd_ptr];
  assign Tx_Full  = (count == CW'(BUF_DEPTH));
  assign Tx_Count = count;
  assign Tx_Busy  = (state != ST_IDLE);

  // bit_cnt counts field bits already on the line (stuffed zeros excluded); ones counts the current run
  always_comb begin
    wr_acc     = Tx_Wr && !Tx_Full;
    last_flag  = (flag_idx == 2'(END_FLAGS - 1));
    abort_go   = Tx_AbortReq && (state inside {ST_START_FLAG, ST_DATA, ST_FCS, ST_END_FLAG});
    stuff_next = ((state == ST_DATA) || (state == ST_FCS)) && (ones == 3'd5);
    accept     = Tx_Enable && (count != '0) &&
                 ((state == ST_IDLE) ||
                  ((state == ST_END_FLAG) && last_flag && (bit_cnt == 5'd8) && !abort_go));
    b2b        = accept && (state == ST_END_FLAG);
    load_byte  = !abort_go &&
                 (((state == ST_START_FLAG) && (bit_cnt == 5'd8)) ||
                  ((state == ST_DATA) && !stuff_next && (bit_cnt == 5'd8) && (bytes_left != '0)) ||
                  b2b);
    rd_amt     = abort_go ? bytes_left : CW'(load_byte);
    data_bit   = load_byte ? rd_byte[0] : shreg[0];
    ones_next  = data_bit ? ones + 3'd1 : 3'd0;
  end

  always_ff @(posedge Clk) begin
    if (wr_acc) mem[wr_ptr] <= Tx_Data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      Tx_Overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + rd_amt[AW-1:0];
      count  <= count + CW'(wr_acc) - rd_amt;
      if (accept) Tx_Overflow <= 1'b0;
      if (Tx_Wr && Tx_Full) Tx_Overflow <= 1'b1;
    end
  end

`ifdef HDLC_FCS_EN
  logic [15:0] crc, fcs;
  logic        data_send;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    crc_upd = (c[0] ^ b) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
  endfunction

  always_comb begin
    data_send = load_byte ||
                ((state == ST_DATA) && !abort_go && !stuff_next && (bit_cnt != 5'd8));
    fcs       = ~crc;
  end

  always_ff @(posedge Clk) begin
    if (Rst)            crc <= 16'hFFFF;
    else if (data_send) crc <= crc_upd(accept ? 16'hFFFF : crc, data_bit);
    else if (accept)    crc <= 16'hFFFF;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      Tx         <= 1'b1;
      TxEN       <= 1'b0;
      Tx_Done    <= 1'b0;
      Tx_Aborted <= 1'b0;
      bit_cnt    <= '0;
      ones       <= '0;
      shreg      <= '0;
      flag_idx   <= '0;
      bytes_left <= '0;
    end else begin
      Tx_Done    <= 1'b0;
      Tx_Aborted <= 1'b0;
      if (abort_go) begin
        state      <= ST_ABORT;
        Tx         <= ABORT_PAT[0];
        bit_cnt    <= 5'd1;
        bytes_left <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state      <= ST_START_FLAG;
              Tx         <= FLAG[0];
              TxEN       <= 1'b1;
              bit_cnt    <= 5'd1;
              bytes_left <= count;
              flag_idx   <= '0;
              ones       <= '0;
            end
          end
          ST_START_FLAG: begin
            if (bit_cnt == 5'd8) begin
              state      <= ST_DATA;
              Tx         <= data_bit;
              ones       <= ones_next;
              shreg      <= {9'd0, rd_byte[7:1]};
              bit_cnt    <= 5'd1;
              bytes_left <= bytes_left - CW'(1);
            end else begin
              Tx      <= FLAG[bit_cnt[2:0]];
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_DATA: begin
            if (stuff_next) begin
              Tx   <= 1'b0;
              ones <= '0;
            end else if ((bit_cnt == 5'd8) && (bytes_left == '0)) begin
`ifdef HDLC_FCS_EN
              state   <= ST_FCS;
              Tx      <= fcs[0];
              ones    <= fcs[0] ? ones + 3'd1 : 3'd0;
              shreg   <= {1'b0, fcs[15:1]};
              bit_cnt <= 5'd1;
`else
              state    <= ST_END_FLAG;
              Tx       <= FLAG[0];
              ones     <= '0;
              bit_cnt  <= 5'd1;
              flag_idx <= '0;
`endif
            end else begin
              Tx   <= data_bit;
              ones <= ones_next;
              if (load_byte) begin
                shreg      <= {9'd0, rd_byte[7:1]};
                bit_cnt    <= 5'd1;
                bytes_left <= bytes_left - CW'(1);
              end else begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`ifdef HDLC_FCS_EN
          ST_FCS: begin
            if (stuff_next) begin
              Tx   <= 1'b0;
              ones <= '0;
            end else if (bit_cnt == 5'd16) begin
              state    <= ST_END_FLAG;
              Tx       <= FLAG[0];
              ones     <= '0;
              bit_cnt  <= 5'd1;
              flag_idx <= '0;
            end else begin
              Tx      <= data_bit;
              ones    <= ones_next;
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
`endif
          ST_END_FLAG: begin
            if (bit_cnt == 5'd8) begin
              if (!last_flag) begin
                flag_idx <= flag_idx + 2'd1;
                Tx       <= FLAG[0];
                bit_cnt  <= 5'd1;
              end else if (b2b) begin
                // closing flag doubles as the next frame's opener
                state      <= ST_DATA;
                Tx         <= data_bit;
                ones       <= ones_next;
                shreg      <= {9'd0, rd_byte[7:1]};
                bit_cnt    <= 5'd1;
                bytes_left <= count - CW'(1);
              end else begin
                state   <= ST_IDLE;
                Tx      <= 1'b1;
                TxEN    <= 1'b0;
                bit_cnt <= '0;
              end
            end else begin
              Tx      <= FLAG[bit_cnt[2:0]];
              bit_cnt <= bit_cnt + 5'd1;
              Tx_Done <= (bit_cnt == 5'd7) && last_flag;
            end
          end
          ST_ABORT: begin
            if (bit_cnt == 5'd8) begin
              state   <= ST_IDLE;
              Tx      <= 1'b1;
              TxEN    <= 1'b0;
              bit_cnt <= '0;
            end else begin
              Tx         <= ABORT_PAT[bit_cnt[2:0]];
              bit_cnt    <= bit_cnt + 5'd1;
              Tx_Aborted <= (bit_cnt == 5'd7);
            end
          end
          default: begin
            state <= ST_IDLE;
            Tx    <= 1'b1;
            TxEN  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: line bits captured per cycle and compared against hand-built frames.
// Covers reset, single byte, CRC check vector (HDLC_FCS_EN), zero stuffing, overflow/wrap, abort, back-to-back.
module tb_hdlc_tx_framer;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, tx_wr, tx_enable, tx_abort;
  logic [7:0]    tx_data;
  logic          tx, txen, busy, full, done, aborted, ovf;
  logic [CW-1:0] count;

  int   checks = 0;
  int   errors = 0;
  logic cap[$];
  logic exp_q[$];
  logic [7:0] frame_bytes[$];
  int   ones_m, done_cnt, done_idx, abt_cnt, abt_idx;
  logic txen_first;

  hdlc_tx_framer #(.BUF_DEPTH(DEPTH), .END_FLAGS(1)) dut (
    .Clk(clk), .Rst(rst), .Tx_Wr(tx_wr), .Tx_Data(tx_data), .Tx_Enable(tx_enable),
    .Tx_AbortReq(tx_abort), .Tx(tx), .TxEN(txen), .Tx_Busy(busy), .Tx_Full(full),
    .Tx_Done(done), .Tx_Aborted(aborted), .Tx_Overflow(ovf), .Tx_Count(count)
  );

  always #5 clk = ~clk;

  task automatic exp_bit(input logic b);
    exp_q.push_back(b);
    if (b) ones_m++; else ones_m = 0;
    if (ones_m == 5) begin
      exp_q.push_back(1'b0);
      ones_m = 0;
    end
  endtask

  task automatic exp_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
    ones_m = 0;
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bit(b[i]);
  endtask

`ifdef HDLC_FCS_EN
  function automatic logic [15:0] model_fcs();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (frame_bytes[k])
      for (int i = 0; i < 8; i++)
        c = (c[0] ^ frame_bytes[k][i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return ~c;
  endfunction
`endif

  // data bytes of frame_bytes plus FCS when built with it
  task automatic exp_payload();
`ifdef HDLC_FCS_EN
    logic [15:0] f;
`endif
    foreach (frame_bytes[k]) exp_byte(frame_bytes[k]);
`ifdef HDLC_FCS_EN
    f = model_fcs();
    exp_byte(f[7:0]);
    exp_byte(f[15:8]);
`endif
  endtask

  function automatic int first_diff();
    int n;
    n = (cap.size() > exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (i >= cap.size() || i >= exp_q.size() || cap[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    tx_wr = 1'b1; tx_data = b;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic send_capture(input int abort_at, input int wr_at, input logic [7:0] wr_b, input int en_at);
    int guard;
    tx_enable = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0;
    txen_first = txen;
    cap.delete();
    done_cnt = 0; done_idx = -1; abt_cnt = 0; abt_idx = -1; guard = 0;
    while (txen === 1'b1 && guard < 3000) begin
      cap.push_back(tx);
      if (done === 1'b1) begin done_cnt++; done_idx = cap.size() - 1; end
      if (aborted === 1'b1) begin abt_cnt++; abt_idx = cap.size() - 1; end
      tx_abort  = (cap.size() - 1 == abort_at);
      tx_wr     = (cap.size() - 1 == wr_at);
      tx_data   = wr_b;
      tx_enable = (cap.size() - 1 == en_at);
      @(negedge clk);
      guard++;
    end
    tx_abort = 1'b0; tx_wr = 1'b0; tx_enable = 1'b0;
    checks++;
    if (guard >= 3000) begin errors++; $display("FAIL capture_timeout TxEN still high after %0d cycles", guard); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_wr = 1'b0; tx_enable = 1'b0; tx_abort = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (txen !== 1'b0)    begin errors++; $display("FAIL reset_txen got %b want 0", txen); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", aborted); end
    checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_overflow got %b want 0", ovf); end
    checks++; if (count !== '0)     begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int d;
    write_byte(8'h01);
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    exp_q.delete(); ones_m = 0; frame_bytes = {8'h01};
    exp_flag(); exp_payload(); exp_flag();
    send_capture(-1, -1, 8'h00, -1);
    checks++; if (txen_first !== 1'b1) begin errors++; $display("FAIL single_latency TxEN got %b want 1", txen_first); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL single_bits first diff at bit %0d (len %0d want %0d)", d, cap.size(), exp_q.size()); end
    checks++; if (done_cnt != 1 || done_idx != exp_q.size() - 1)
      begin errors++; $display("FAIL single_done got %0d pulses at %0d want 1 at %0d", done_cnt, done_idx, exp_q.size() - 1); end
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_idle Tx=%b Busy=%b want 1/0", tx, busy); end
    checks++; if (count !== '0) begin errors++; $display("FAIL single_count_after got %0d want 0", count); end
  endtask

`ifdef HDLC_FCS_EN
  task automatic test_fcs_check();
    int d;
    exp_q.delete(); ones_m = 0;
    exp_flag();
    for (int i = 0; i < 9; i++) begin
      write_byte(8'h31 + 8'(i));
      exp_byte(8'h31 + 8'(i));
    end
    exp_byte(8'h6E); exp_byte(8'h90); exp_flag();
    send_capture(-1, -1, 8'h00, -1);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL fcs_123456789 first diff at bit %0d (len %0d want %0d)", d, cap.size(), exp_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL fcs_done got %0d pulses want 1", done_cnt); end
  endtask
`endif

  task automatic test_stuffing();
    logic [8:0]  s9, s9_exp;
    logic [17:0] s18, s18_exp;
    int d;
    write_byte(8'hFF);
    exp_q.delete(); ones_m = 0; frame_bytes = {8'hFF};
    exp_flag(); exp_payload(); exp_flag();
    send_capture(-1, -1, 8'h00, -1);
    s9_exp = 9'b111011111;
    for (int i = 0; i < 9; i++) s9[i] = (8 + i < cap.size()) ? cap[8 + i] : 1'bx;
    checks++; if (s9 !== s9_exp) begin errors++; $display("FAIL stuff_ff data bits got %b want %b", s9, s9_exp); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL stuff_ff_frame first diff at bit %0d", d); end

    write_byte(8'h3E); write_byte(8'h1F);
    exp_q.delete(); ones_m = 0; frame_bytes = {8'h3E, 8'h1F};
    exp_flag(); exp_payload(); exp_flag();
    send_capture(-1, -1, 8'h00, -1);
    s18_exp = 18'b000011111000111110;
    for (int i = 0; i < 18; i++) s18[i] = (8 + i < cap.size()) ? cap[8 + i] : 1'bx;
    checks++; if (s18 !== s18_exp) begin errors++; $display("FAIL stuff_3e1f data bits got %b want %b", s18, s18_exp); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL stuff_3e1f_frame first diff at bit %0d", d); end
  endtask

  task automatic test_overflow_wrap();
    int d;
    frame_bytes.delete();
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'h80 + 8'(i * 7));
      frame_bytes.push_back(8'h80 + 8'(i * 7));
    end
    checks++; if (full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL fill_flags Full=%b Ovf=%b want 1/0", full, ovf); end
    write_byte(8'h55);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", ovf); end
    checks++; if (count !== CW'(DEPTH) || full !== 1'b1)
      begin errors++; $display("FAIL overflow_count got %0d full %b want %0d full 1", count, full, DEPTH); end
    exp_q.delete(); ones_m = 0;
    exp_flag(); exp_payload(); exp_flag();
    send_capture(-1, -1, 8'h00, -1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b want 0", ovf); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL full_frame first diff at bit %0d (len %0d want %0d)", d, cap.size(), exp_q.size()); end

    write_byte(8'h12); write_byte(8'h34);
    exp_q.delete(); ones_m = 0; frame_bytes = {8'h12, 8'h34};
    exp_flag(); exp_payload(); exp_flag();
    send_capture(-1, -1, 8'h00, -1);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL wrap_frame first diff at bit %0d", d); end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    int d;
    write_byte(8'h55); write_byte(8'hAA); write_byte(8'h0F); write_byte(8'hF0);
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL abort_count_before got %0d want 4", count); end
    exp_q.delete(); ones_m = 0;
    exp_flag();
    b = 8'h55;
    for (int i = 0; i < 5; i++) exp_bit(b[i]);
    b = 8'hFE;
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    send_capture(12, -1, 8'h00, -1);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL abort_bits first diff at bit %0d (len %0d want %0d)", d, cap.size(), exp_q.size()); end
    checks++; if (abt_cnt != 1 || abt_idx != exp_q.size() - 1)
      begin errors++; $display("FAIL abort_pulse got %0d at %0d want 1 at %0d", abt_cnt, abt_idx, exp_q.size() - 1); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt); end
    checks++; if (count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after count %0d busy %b want 0/0", count, busy); end
  endtask

  task automatic test_back_to_back();
    int en_at, d;
    write_byte(8'h01);
    exp_q.delete(); ones_m = 0; frame_bytes = {8'h01};
    exp_flag(); exp_payload(); exp_flag();
    en_at = exp_q.size() - 1;
    frame_bytes = {8'h02};
    exp_payload(); exp_flag();
    send_capture(-1, 3, 8'h02, en_at);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL b2b_bits first diff at bit %0d (len %0d want %0d)", d, cap.size(), exp_q.size()); end
    checks++; if (done_cnt != 2 || done_idx != exp_q.size() - 1)
      begin errors++; $display("FAIL b2b_done got %0d pulses last at %0d want 2 last at %0d", done_cnt, done_idx, exp_q.size() - 1); end
    checks++; if (count !== '0) begin errors++; $display("FAIL b2b_count got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
`ifdef HDLC_FCS_EN
    test_fcs_check();
`endif
    test_stuffing();
    test_overflow_wrap();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
